// File: rtl/des_feistel_stage.sv
// des_feistel_stage: two-stage pipelined DES round function f(R, K).
// Stage 1 registers x = E(r_in) ^ subkey; stage 2 runs the S-boxes and the
// P permutation and registers f_out. Valid/ready handshake on both sides.
// Optional build macro DES_FEISTEL_XOR_L_EN adds l_in, carried with stage 1,
// so that f_out becomes the new right half L ^ f(R, K).
// Bit numbering: vector bit [msb] is DES bit 1.

module Sbox1 (input logic [5:0] data_in, output logic [3:0] data_out);
  localparam logic [255:0] tbl = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
  logic [7:0] lo;
  // row = outer bits, column = inner four bits; table is row-major from the MSB
  assign lo = 8'd252 - {data_in[5], data_in[0], data_in[4:1], 2'b00};
  assign data_out = tbl[lo +: 4];
endmodule

module Sbox2 (input logic [5:0] data_in, output logic [3:0] data_out);
  localparam logic [255:0] tbl = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
  logic [7:0] lo;
  // row = outer bits, column = inner four bits
  assign lo = 8'd252 - {data_in[5], data_in[0], data_in[4:1], 2'b00};
  assign data_out = tbl[lo +: 4];
endmodule

module Sbox3 (input logic [5:0] data_in, output logic [3:0] data_out);
  localparam logic [255:0] tbl = 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
  logic [7:0] lo;
  // row = outer bits, column = inner four bits
  assign lo = 8'd252 - {data_in[5], data_in[0], data_in[4:1], 2'b00};
  assign data_out = tbl[lo +: 4];
endmodule

module Sbox4 (input logic [5:0] data_in, output logic [3:0] data_out);
  localparam logic [255:0] tbl = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
  logic [7:0] lo;
  // row = outer bits, column = inner four bits
  assign lo = 8'd252 - {data_in[5], data_in[0], data_in[4:1], 2'b00};
  assign data_out = tbl[lo +: 4];
endmodule

module Sbox5 (input logic [5:0] data_in, output logic [3:0] data_out);
  localparam logic [255:0] tbl = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
  logic [7:0] lo;
  // row = outer bits, column = inner four bits
  assign lo = 8'd252 - {data_in[5], data_in[0], data_in[4:1], 2'b00};
  assign data_out = tbl[lo +: 4];
endmodule

module Sbox6 (input logic [5:0] data_in, output logic [3:0] data_out);
  localparam logic [255:0] tbl = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
  logic [7:0] lo;
  // row = outer bits, column = inner four bits
  assign lo = 8'd252 - {data_in[5], data_in[0], data_in[4:1], 2'b00};
  assign data_out = tbl[lo +: 4];
endmodule

module Sbox7 (input logic [5:0] data_in, output logic [3:0] data_out);
  localparam logic [255:0] tbl = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
  logic [7:0] lo;
  // row = outer bits, column = inner four bits
  assign lo = 8'd252 - {data_in[5], data_in[0], data_in[4:1], 2'b00};
  assign data_out = tbl[lo +: 4];
endmodule

module Sbox8 (input logic [5:0] data_in, output logic [3:0] data_out);
  localparam logic [255:0] tbl = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;
  logic [7:0] lo;
  // row = outer bits, column = inner four bits
  assign lo = 8'd252 - {data_in[5], data_in[0], data_in[4:1], 2'b00};
  assign data_out = tbl[lo +: 4];
endmodule

module des_feistel_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] r_in,
  input  logic [47:0] subkey,
`ifdef DES_FEISTEL_XOR_L_EN
  input  logic [31:0] l_in,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] f_out
);

  logic        s1_valid;
  logic [47:0] x_q;
  logic [47:0] e_out;
  logic [31:0] s_out;
  logic [31:0] p_out;
  logic [31:0] f_next;
  logic        s2_adv;

  // E expansion: each 6-bit group takes 4 bits plus one neighbour on each side
  assign e_out = {r_in[0],  r_in[31:27],
                  r_in[28:23],
                  r_in[24:19],
                  r_in[20:15],
                  r_in[16:11],
                  r_in[12:7],
                  r_in[8:3],
                  r_in[4:0],  r_in[31]};

  // stage 2 can take new data when empty or when its output leaves this cycle
  assign s2_adv   = ~out_valid | out_ready;
  assign in_ready = ~s1_valid | s2_adv;

  Sbox1 u_sbox1 (.data_in(x_q[47:42]), .data_out(s_out[31:28]));
  Sbox2 u_sbox2 (.data_in(x_q[41:36]), .data_out(s_out[27:24]));
  Sbox3 u_sbox3 (.data_in(x_q[35:30]), .data_out(s_out[23:20]));
  Sbox4 u_sbox4 (.data_in(x_q[29:24]), .data_out(s_out[19:16]));
  Sbox5 u_sbox5 (.data_in(x_q[23:18]), .data_out(s_out[15:12]));
  Sbox6 u_sbox6 (.data_in(x_q[17:12]), .data_out(s_out[11:8]));
  Sbox7 u_sbox7 (.data_in(x_q[11:6]),  .data_out(s_out[7:4]));
  Sbox8 u_sbox8 (.data_in(x_q[5:0]),   .data_out(s_out[3:0]));

  // P permutation: output DES bit i takes S-output DES bit P[i]
  assign p_out = {s_out[16], s_out[25], s_out[12], s_out[11],
                  s_out[3],  s_out[20], s_out[4],  s_out[15],
                  s_out[31], s_out[17], s_out[9],  s_out[6],
                  s_out[27], s_out[14], s_out[1],  s_out[22],
                  s_out[30], s_out[24], s_out[8],  s_out[18],
                  s_out[0],  s_out[5],  s_out[29], s_out[23],
                  s_out[13], s_out[19], s_out[2],  s_out[26],
                  s_out[10], s_out[21], s_out[28], s_out[7]};

`ifdef DES_FEISTEL_XOR_L_EN
  logic [31:0] l_q;

  // left half rides along with stage 1 so it lines up with x_q
  always_ff @(posedge clk) begin
    if (rst)
      l_q <= 32'd0;
    else if (in_ready && in_valid)
      l_q <= l_in;
  end

  assign f_next = p_out ^ l_q;
`else
  assign f_next = p_out;
`endif

  // stage 1: capture expanded-and-keyed right half on an input transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      x_q      <= 48'd0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid)
        x_q <= e_out ^ subkey;
    end
  end

  // stage 2: register f result; hold while downstream stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      f_out     <= 32'd0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid)
        f_out <= f_next;
    end
  end

endmodule

// File: tb/tb_des_feistel_stage.sv
// Bench for des_feistel_stage: known vector, streaming, backpressure,
// mid-flight reset, exhaustive S-box paths and random handshaking, all
// compared against a table-driven software model of the DES f function.
module tb_des_feistel_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] r_in;
  logic [47:0] subkey;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] f_out;
`ifdef DES_FEISTEL_XOR_L_EN
  logic [31:0] l_in;
  localparam logic [31:0] lmask = 32'hFFFF_FFFF;
  localparam logic [31:0] kv_exp = 32'hEF4A_6544;
`else
  localparam logic [31:0] lmask = 32'h0000_0000;
  localparam logic [31:0] kv_exp = 32'h234A_A9BB;
`endif

  int checks = 0;
  int errors = 0;

  des_feistel_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .r_in(r_in), .subkey(subkey),
`ifdef DES_FEISTEL_XOR_L_EN
    .l_in(l_in),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .f_out(f_out));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int e_tab [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                     16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  int p_tab [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                     2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  int s_tab [8][4][16] = '{
    '{'{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7}, '{0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8},
      '{4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0}, '{15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13}},
    '{'{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10}, '{3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5},
      '{0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15}, '{13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9}},
    '{'{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8}, '{13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1},
      '{13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7}, '{1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12}},
    '{'{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15}, '{13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9},
      '{10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4}, '{3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14}},
    '{'{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9}, '{14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6},
      '{4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14}, '{11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3}},
    '{'{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11}, '{10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8},
      '{9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6}, '{4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13}},
    '{'{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1}, '{13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6},
      '{1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2}, '{6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12}},
    '{'{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7}, '{1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2},
      '{7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8}, '{2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}}};

  // software DES f (plus optional left-half XOR), from the standard tables
  function automatic logic [31:0] model_f(input logic [31:0] r, input logic [47:0] k,
                                          input logic [31:0] l);
    logic [47:0] x;
    logic [31:0] s;
    logic [31:0] p;
    int six, row, col;
    for (int i = 0; i < 48; i++) x[47-i] = r[32-e_tab[i]];
    x = x ^ k;
    for (int b = 0; b < 8; b++) begin
      six = int'(x[47-6*b -: 6]);
      row = ((six >> 5) & 1) * 2 + (six & 1);
      col = (six >> 1) & 15;
      s[31-4*b -: 4] = 4'(s_tab[b][row][col]);
    end
    for (int i = 0; i < 32; i++) p[31-i] = s[32-p_tab[i]];
    return p ^ (l & lmask);
  endfunction

  function automatic logic [47:0] rand48();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[47:0];
  endfunction

  task automatic drive(input logic v, input logic [31:0] r, input logic [47:0] k,
                       input logic [31:0] l);
    in_valid = v;
    r_in     = r;
    subkey   = k;
`ifdef DES_FEISTEL_XOR_L_EN
    l_in     = l;
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 32'd0, 48'd0, 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (f_out !== 32'd0) begin errors++; $display("FAIL reset_f_out got %h want 00000000", f_out); end
  endtask

  task automatic test_known_vector();
    do_reset();
    drive(1'b1, 32'hF0AA_F0AA, 48'h1B02_EFFC_7072, 32'hCC00_CCFF);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL kv_in_ready got %b want 1", in_ready); end
    @(negedge clk);
    drive(1'b0, 32'd0, 48'd0, 32'd0);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL kv_early_valid got %b want 0", out_valid); end
    @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL kv_valid got %b want 1", out_valid); end
    checks++; if (f_out !== kv_exp) begin errors++; $display("FAIL kv_f_out got %h want %h", f_out, kv_exp); end
    @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL kv_single got %b want 0", out_valid); end
  endtask

  task automatic test_streaming();
    logic [31:0] exp_f [16];
    logic [31:0] r, l;
    logic [47:0] k;
    do_reset();
    for (int c = 0; c <= 18; c++) begin
      @(negedge clk);
      if (c < 16) begin
        r = $urandom(); k = rand48(); l = $urandom();
        exp_f[c] = model_f(r, k, l);
        drive(1'b1, r, k, l);
      end else drive(1'b0, 32'd0, 48'd0, 32'd0);
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready c=%0d got %b want 1", c, in_ready); end
      if (c >= 2 && c < 18) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid c=%0d got %b want 1", c, out_valid); end
        checks++; if (f_out !== exp_f[c-2]) begin errors++; $display("FAIL stream_data c=%0d got %h want %h", c, f_out, exp_f[c-2]); end
      end else begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_idle c=%0d got %b want 0", c, out_valid); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rv [3], lv [3], exp_f [3];
    logic [47:0] kv [3];
    logic        ir_exp [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    int nxt, got, c;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      rv[i] = $urandom(); kv[i] = rand48(); lv[i] = $urandom();
      exp_f[i] = model_f(rv[i], kv[i], lv[i]);
    end
    nxt = 0; got = 0; c = 0;
    while (got < 3 && c < 30) begin
      @(negedge clk);
      if (nxt < 3) drive(1'b1, rv[nxt], kv[nxt], lv[nxt]);
      else drive(1'b0, 32'd0, 48'd0, 32'd0);
      out_ready = (c >= 5);
      #1;
      if (c < 5) begin
        checks++; if (in_ready !== ir_exp[c]) begin errors++; $display("FAIL bp_in_ready c=%0d got %b want %b", c, in_ready, ir_exp[c]); end
      end
      if (c >= 2 && c < 5) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid c=%0d got %b want 1", c, out_valid); end
        checks++; if (f_out !== exp_f[0]) begin errors++; $display("FAIL bp_hold_data c=%0d got %h want %h", c, f_out, exp_f[0]); end
      end
      if (out_valid && out_ready) begin
        checks++; if (f_out !== exp_f[got]) begin errors++; $display("FAIL bp_order n=%0d got %h want %h", got, f_out, exp_f[got]); end
        got++;
      end
      if (in_valid && in_ready) nxt++;
      if (c == 4) begin
        checks++; if (nxt !== 2) begin errors++; $display("FAIL bp_accepted got %0d want 2", nxt); end
      end
      c++;
    end
    checks++; if (got !== 3) begin errors++; $display("FAIL bp_delivered got %0d want 3", got); end
  endtask

  task automatic test_midflight_reset();
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, $urandom(), rand48(), $urandom());
    @(negedge clk);
    drive(1'b1, $urandom(), rand48(), $urandom());
    @(negedge clk);
    drive(1'b0, 32'd0, 48'd0, 32'd0);
    #1;
    checks++; if ({out_valid, in_ready} !== 2'b10) begin errors++; $display("FAIL mr_full got %b want 10", {out_valid, in_ready}); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mr_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mr_in_ready got %b want 1", in_ready); end
    checks++; if (f_out !== 32'd0) begin errors++; $display("FAIL mr_f_out got %h want 00000000", f_out); end
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mr_no_ghost got %b want 0", out_valid); end
  endtask

  task automatic test_sbox_exhaustive();
    logic [31:0] exp_f [512];
    logic [47:0] k;
    logic [31:0] l;
    do_reset();
    for (int c = 0; c <= 513; c++) begin
      @(negedge clk);
      if (c < 512) begin
        k = 48'(c % 64) << (42 - 6 * (c / 64));
        l = $urandom();
        exp_f[c] = model_f(32'd0, k, l);
        drive(1'b1, 32'd0, k, l);
      end else drive(1'b0, 32'd0, 48'd0, 32'd0);
      out_ready = 1'b1;
      #1;
      if (c >= 2) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sbox_valid n=%0d got %b want 1", c-2, out_valid); end
        checks++; if (f_out !== exp_f[c-2]) begin errors++; $display("FAIL sbox_data box=%0d v=%0d got %h want %h", (c-2)/64+1, (c-2)%64, f_out, exp_f[c-2]); end
      end
    end
  endtask

  task automatic test_random_handshake();
    logic [31:0] q [$];
    logic [31:0] r, l, prev_f;
    logic [47:0] k;
    logic        iv, orr, prev_hold;
    int occ;
    do_reset();
    occ = 0; prev_hold = 1'b0; prev_f = 32'd0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      iv  = (c < 260) ? 1'($urandom_range(0, 1)) : 1'b0;
      orr = (c < 260) ? ($urandom_range(0, 3) != 0) : 1'b1;
      r = $urandom(); k = rand48(); l = $urandom();
      drive(iv, r, k, l);
      out_ready = orr;
      #1;
      if (prev_hold) begin
        checks++; if (out_valid !== 1'b1 || f_out !== prev_f) begin errors++; $display("FAIL rnd_stable c=%0d got %b/%h want 1/%h", c, out_valid, f_out, prev_f); end
      end
      checks++; if (in_ready !== ((occ < 2) || orr)) begin errors++; $display("FAIL rnd_in_ready c=%0d got %b want %b", c, in_ready, (occ < 2) || orr); end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL rnd_extra c=%0d got %h want none", c, f_out); end
        else begin
          if (f_out !== q[0]) begin errors++; $display("FAIL rnd_data c=%0d got %h want %h", c, f_out, q[0]); end
          void'(q.pop_front());
          occ--;
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model_f(r, k, l));
        occ++;
      end
      prev_hold = out_valid && !out_ready;
      prev_f = f_out;
    end
    checks++; if (q.size() !== 0) begin errors++; $display("FAIL rnd_drain got %0d left want 0", q.size()); end
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 32'd0, 48'd0, 32'd0);
    test_reset();
    test_known_vector();
    test_streaming();
    test_backpressure();
    test_midflight_reset();
    test_sbox_exhaustive();
    test_random_handshake();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/des_feistel_stage.md
DES_FEISTEL_STAGE -- requirements
Module: des_feistel_stage

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have the port in_valid, input, 1 bit: r_in and subkey are valid this cycle.
REQ-004 The block SHALL have the port in_ready, output, 1 bit: the block accepts the input this cycle.
REQ-005 The block SHALL have the port r_in, input, 32 bits: the DES right half; r_in[31] is DES bit 1.
REQ-006 The block SHALL have the port subkey, input, 48 bits: the round key; subkey[47] is DES bit 1.
REQ-007 The block SHALL have the port out_valid, output, 1 bit: f_out is valid.
REQ-008 The block SHALL have the port out_ready, input, 1 bit: the downstream stage consumes f_out this cycle.
REQ-009 The block SHALL have the port f_out, output, 32 bits: the Feistel function result; f_out[31] is DES bit 1.

Function
REQ-010 Input transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1; output transfer SHALL occur where out_valid=1 and out_ready=1.
REQ-011 Stage 1 SHALL register x = E(r_in) XOR subkey (48 bits), using the standard DES E table, together with a stage-1 valid flag.
REQ-012 Stage 2 SHALL split x into six-bit slices: x[47:42] feeds existing module Sbox1, x[41:36] feeds Sbox2, and so on, with x[5:0] feeding Sbox8; each slice connects to the module's data_in unchanged.
REQ-013 The Sbox1..Sbox8 data_out values SHALL be concatenated as s[31:28]=Sbox1 through s[3:0]=Sbox8, then permuted with the standard DES P table, and the result registered into f_out with out_valid.
REQ-014 Latency SHALL be exactly 2 cycles from an input transfer to out_valid=1 when out_ready is held at 1.
REQ-015 Throughput SHALL be 1 transfer per cycle with no bubbles while out_ready=1.
REQ-016 Each stage SHALL load when it is empty, or when its contents move on in the same cycle; otherwise it SHALL hold its data and valid flag unchanged.
REQ-017 in_ready SHALL equal NOT s1_valid OR (NOT out_valid OR out_ready), combinationally; no path from in_valid to in_ready is permitted.
REQ-018 While out_valid=1 and out_ready=0, f_out and out_valid SHALL remain stable.
REQ-019 With both stages full and out_ready=0, in_ready SHALL be 0 and no data SHALL be lost or duplicated.
REQ-020 A simultaneous input transfer and output transfer SHALL both take effect in the same cycle.
REQ-021 The block SHALL contain exactly 2 pipeline stages; no other buffering is permitted.

Reset
REQ-022 When rst=1 at a clock edge, both valid flags, the stage-1 register and f_out SHALL clear to 0.
REQ-023 Reset SHALL discard in-flight data mid-operation; out_valid SHALL be 0 in the first cycle after reset.
REQ-024 in_ready SHALL be 1 in the first cycle after reset.

Configuration
REQ-025 When macro DES_FEISTEL_XOR_L_EN is defined, the block SHALL add the port l_in, input, 32 bits, captured with r_in, carried alongside the data through stage 1, and f_out SHALL equal P(S(x)) XOR l_in, forming the new right half of the round.
REQ-026 When DES_FEISTEL_XOR_L_EN is not defined, the l_in port and its pipeline register SHALL NOT exist, and f_out SHALL equal P(S(x)).
REQ-027 Latency, handshake and reset behaviour SHALL be identical with and without DES_FEISTEL_XOR_L_EN.

Verification
REQ-028 The bench SHALL cover a known vector: r_in=F0AAF0AA and subkey=1B02EFFC7072 -> stage-1 x=6117BA866527, S output 5C82B597, f_out=234AA9BB two cycles after the transfer.
REQ-029 The bench SHALL cover the macro variant: with DES_FEISTEL_XOR_L_EN defined, the REQ-028 vector plus l_in=CC00CCFF -> f_out=EF4A6544.
REQ-030 The bench SHALL cover streaming: 16 random back-to-back inputs with out_ready=1 -> 16 outputs on consecutive cycles, each matching a software DES f model, in order.
REQ-031 The bench SHALL cover backpressure: hold out_ready=0 for 5 cycles after 3 inputs offered -> in_ready=0 after 2 accepted, f_out stable, then all 3 results delivered in order.
REQ-032 The bench SHALL cover mid-flight reset: assert rst for 1 cycle with both stages full -> next cycle out_valid=0, in_ready=1, f_out=00000000.
REQ-033 The bench SHALL cover an exhaustive S-box path check: for each k in 1..8 and each 6-bit value v, drive the stage-1 x slice k to v (other slices 0) -> f_out matches P of the expected table output.
